// File: rtl/toggle_hs_pkg.sv
// Shared types and sizing for the two-phase handshake receiver and its output FIFO.
package toggle_hs_pkg;

    localparam int DATA_W     = 8;
    localparam int FIFO_DEPTH = 2;
    localparam int CNT_W      = 8;
    localparam int PTR_W      = $clog2(FIFO_DEPTH);

    // Occupancy value that means "full", sized to match the FIFO count register
    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CAPT = 2'd1,
        ACK  = 2'd2
    } state_t;

    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
        return c + 1'b1;
    endfunction

endpackage

// File: rtl/hs_fifo2.sv
// Two-entry first-word-fall-through FIFO; full is judged before any same-cycle pop.
module hs_fifo2
    import toggle_hs_pkg::*;
(
    input  logic              clk,
    input  logic              clear,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    output logic [DATA_W-1:0] dout,
    output logic              empty,
    output logic              full
);

    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W:0]    r_count;

    logic w_push;
    logic w_pop;

    assign empty  = (r_count == '0);
    assign full   = (r_count == DEPTH_CNT);
    assign w_push = push & ~full;
    assign w_pop  = pop & ~empty;
    assign dout   = r_mem[r_rd_ptr];

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= din;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/toggle_hs_rx.sv
// Two-phase (toggle) handshake receiver: synchronizes req_tog, captures data_in into
// a 2-entry FIFO and answers each accepted word with one ack_tog level change.
module toggle_hs_rx
    import toggle_hs_pkg::*;
(
    input  logic              clk,
    input  logic              clear,
    input  logic              req_tog,
    input  logic [DATA_W-1:0] data_in,
    output logic              ack_tog,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  word_cnt
);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_req_prev;
    state_t           r_state;
    logic             r_ack_tog;
    logic [CNT_W-1:0] r_word_cnt;

    logic w_req_edge;
    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    assign w_req_edge = r_sync2 ^ r_req_prev;
    assign w_push     = (r_state == CAPT) & ~w_full;
    assign w_pop      = out_ready & ~w_empty;

    assign ack_tog   = r_ack_tog;
    assign out_valid = ~w_empty;
    assign word_cnt  = r_word_cnt;

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= req_tog;
            r_sync2 <= r_sync1;
        end
    end

    // data_in is held by the sender until our ack, so it is safe to sample in CAPT
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_state    <= IDLE;
            r_req_prev <= 1'b0;
            r_ack_tog  <= 1'b0;
            r_word_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req_edge) begin
                        r_req_prev <= r_sync2;
                        r_state    <= CAPT;
                    end
                end
                CAPT: begin
                    if (!w_full) begin
                        r_word_cnt <= cnt_inc(r_word_cnt);
                        r_state    <= ACK;
                    end
                end
                ACK: begin
                    r_ack_tog <= ~r_ack_tog;
                    r_state   <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    hs_fifo2 u_fifo (
        .clk   (clk),
        .clear (clear),
        .push  (w_push),
        .din   (data_in),
        .pop   (w_pop),
        .dout  (out_data),
        .empty (w_empty),
        .full  (w_full)
    );

endmodule

// File: tb/tb_toggle_hs_rx.sv
// Directed bench for toggle_hs_rx: latency, backpressure, push/pop overlap, reset and wrap.
module tb_toggle_hs_rx;
    import toggle_hs_pkg::*;

    logic       clk;
    logic       clear;
    logic       req_tog;
    logic [7:0] data_in;
    logic       ack_tog;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic [7:0] word_cnt;

    int n_checks;
    int n_pass;
    int n_acks;

    toggle_hs_rx dut (
        .clk       (clk),
        .clear     (clear),
        .req_tog   (req_tog),
        .data_in   (data_in),
        .ack_tog   (ack_tog),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .word_cnt  (word_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input string tag, input logic lvl);
        int k;
        k = 0;
        while (ack_tog !== lvl && k < 20) begin
            tick();
            k++;
        end
        check(tag, 32'(ack_tog), 32'(lvl));
        if (ack_tog === lvl) n_acks++;
    endtask

    task automatic wait_capt(input string tag);
        int k;
        k = 0;
        while (dut.r_state !== CAPT && k < 20) begin
            tick();
            k++;
        end
        check(tag, 32'(dut.r_state), 32'(CAPT));
    endtask

    task automatic send(input string tag, input logic [7:0] d);
        logic old;
        old     = ack_tog;
        data_in = d;
        req_tog = ~req_tog;
        wait_ack(tag, ~old);
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic do_reset(input logic req_lvl);
        clear   = 1'b1;
        req_tog = req_lvl;
        tick();
        tick();
        clear = 1'b0;
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        n_acks    = 0;
        clear     = 1'b1;
        req_tog   = 1'b0;
        data_in   = 8'h00;
        out_ready = 1'b0;
        tick();
        tick();
        check("rst_ack", 32'(ack_tog), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_cnt", 32'(word_cnt), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_state", 32'(dut.r_state), 32'(IDLE));
        clear = 1'b0;
        tick();

        // Single word: toggle lands before edge k
        data_in = 8'hA5;
        req_tog = 1'b1;
        tick();
        tick();
        tick();
        check("lat_capt_k2", 32'(dut.r_state), 32'(CAPT));
        check("lat_valid_k2", 32'(out_valid), 32'd0);
        tick();
        check("lat_valid_k3", 32'(out_valid), 32'd1);
        check("lat_data_k3", 32'(out_data), 32'hA5);
        check("lat_ack_k3", 32'(ack_tog), 32'd0);
        tick();
        check("lat_ack_k4", 32'(ack_tog), 32'd1);
        check("lat_cnt", 32'(word_cnt), 32'd1);

        // Drain, then keep popping while empty
        out_ready = 1'b1;
        tick();
        tick();
        tick();
        check("empty_pop_valid", 32'(out_valid), 32'd0);
        out_ready = 1'b0;
        tick();
        check("empty_pop_valid2", 32'(out_valid), 32'd0);
        check("empty_pop_cnt", 32'(word_cnt), 32'd1);

        // Backpressure: third word stalls in CAPT while FIFO is full
        send("bp_ack11", 8'h11);
        send("bp_ack22", 8'h22);
        data_in = 8'h33;
        req_tog = ~req_tog;
        for (int i = 0; i < 12; i++) tick();
        check("bp_no_ack", 32'(ack_tog), 32'd1);
        check("bp_state", 32'(dut.r_state), 32'(CAPT));
        check("bp_cnt", 32'(word_cnt), 32'd3);
        check("bp_head", 32'(out_data), 32'h11);
        pop_one();
        check("bp_head_after_pop", 32'(out_data), 32'h22);
        check("bp_state_after_pop", 32'(dut.r_state), 32'(CAPT));
        tick();
        check("bp_state_ack", 32'(dut.r_state), 32'(ACK));
        check("bp_cnt4", 32'(word_cnt), 32'd4);
        tick();
        check("bp_third_ack", 32'(ack_tog), 32'd0);
        check("bp_out22", 32'(out_data), 32'h22);
        pop_one();
        check("bp_out33", 32'(out_data), 32'h33);
        pop_one();
        check("bp_drained", 32'(out_valid), 32'd0);

        // Push and pop together with one entry
        send("pp_ack11", 8'h11);
        data_in = 8'h22;
        req_tog = ~req_tog;
        wait_capt("pp_capt");
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("pp_valid", 32'(out_valid), 32'd1);
        check("pp_data", 32'(out_data), 32'h22);
        tick();
        check("pp_ack", 32'(ack_tog), 32'd0);
        check("pp_cnt", 32'(word_cnt), 32'd6);
        pop_one();
        check("pp_occ_one", 32'(out_valid), 32'd0);

        // Reset asserted while in CAPT discards the word
        data_in = 8'h77;
        req_tog = ~req_tog;
        wait_capt("mid_capt");
        clear   = 1'b1;
        req_tog = 1'b0;
        #1;
        check("mid_ack", 32'(ack_tog), 32'd0);
        check("mid_valid", 32'(out_valid), 32'd0);
        check("mid_cnt", 32'(word_cnt), 32'd0);
        check("mid_state", 32'(dut.r_state), 32'(IDLE));
        tick();
        tick();
        clear = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check("mid_quiet_ack", 32'(ack_tog), 32'd0);
        check("mid_quiet_valid", 32'(out_valid), 32'd0);
        send("mid_next_ack", 8'h3C);
        check("mid_next_data", 32'(out_data), 32'h3C);
        check("mid_next_cnt", 32'(word_cnt), 32'd1);
        pop_one();

        // req_tog high across reset release counts as one request
        data_in = 8'hC3;
        do_reset(1'b1);
        wait_ack("rel_ack", 1'b1);
        check("rel_data", 32'(out_data), 32'hC3);
        check("rel_cnt", 32'(word_cnt), 32'd1);
        pop_one();

        // Wrap: 256 words with a consumer that always accepts
        do_reset(1'b0);
        out_ready = 1'b1;
        n_acks    = 0;
        for (int i = 0; i < 256; i++) begin
            send("wrap_ack", 8'(i));
            if (i == 254) check("wrap_cnt255", 32'(word_cnt), 32'd255);
        end
        tick();
        check("wrap_cnt0", 32'(word_cnt), 32'd0);
        check("wrap_ack_lvl", 32'(ack_tog), 32'd0);
        check("wrap_n_acks", 32'(n_acks), 32'd256);
        check("wrap_valid", 32'(out_valid), 32'd0);
        out_ready = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/toggle_hs_rx.md
TOGGLE_HS_RX -- requirements
Module: toggle_hs_rx

Interface
REQ-001 clk  input  1  single clock; all state updates on posedge clk.
REQ-002 clear  input  1  asynchronous, active-high reset; acts immediately on assertion, independent of clk.
REQ-003 req_tog  input  1  two-phase request from sender; each level change = one new word; asynchronous to clk.
REQ-004 data_in  input  8  word from sender; held stable by sender from its req_tog toggle until the matching ack_tog toggle.
REQ-005 ack_tog  output  1  two-phase acknowledge; toggles once per accepted word.
REQ-006 out_valid  output  1  high while the output buffer is non-empty.
REQ-007 out_data  output  8  head-of-buffer word; meaningful only when out_valid=1.
REQ-008 out_ready  input  1  consumer accepts head word on posedge clk when out_valid=1 and out_ready=1.
REQ-009 word_cnt  output  8  count of words written into the buffer; wraps 255->0.

Function
REQ-010 req_tog SHALL pass through a 2-flop synchronizer (sync1, sync2) before use; a request edge = sync2 != req_prev.
REQ-011 FSM states SHALL be IDLE, CAPT, ACK.
REQ-012 IDLE: on a request edge -> CAPT, and req_prev <= sync2 on the same clock (edge consumed); otherwise stay IDLE.
REQ-013 CAPT: if buffer not full -> write data_in, increment word_cnt, go to ACK; if full -> stay CAPT, no write, no ack.
REQ-014 ACK: ack_tog <= ~ack_tog, go to IDLE.
REQ-015 Latency: toggle of req_tog set up before posedge k -> CAPT after posedge k+2, out_valid=1 after posedge k+3 (buffer previously empty), ack_tog toggled after posedge k+4.
REQ-016 Output buffer SHALL be a 2-entry FIFO; pop when out_valid & out_ready; out_data = oldest entry.
REQ-017 Simultaneous push and pop when full: push blocked that cycle (full is evaluated before the pop); pop proceeds; push occurs on the next cycle.
REQ-018 Simultaneous push and pop with 1 entry: both occur; occupancy stays 1; out_data becomes the new word.
REQ-019 Pop with out_ready=1 and out_valid=0 SHALL have no effect.
REQ-020 A second req_tog toggle before ack_tog toggles violates the protocol; behaviour is undefined, but the block SHALL NOT lock up (FSM always returns to IDLE).
REQ-021 word_cnt SHALL be 8-bit unsigned with modulo-256 wrap; no saturation.

Reset
REQ-022 While clear=1: state=IDLE, sync1=sync2=req_prev=0, ack_tog=0, buffer empty (out_valid=0), out_data=0, word_cnt=0.
REQ-023 clear asserted mid-transfer (CAPT or ACK) SHALL discard the pending word; no ack_tog toggle is issued for it.
REQ-024 After clear deasserts, a req_tog level of 1 SHALL be treated as one new request; sender and receiver are reset together.

Structure
REQ-025 Package toggle_hs_pkg SHALL hold the state enum (IDLE, CAPT, ACK), DATA_W=8, FIFO_DEPTH=2, CNT_W=8.
REQ-026 The 2-entry FIFO SHALL be a sub-module hs_fifo2 (clk, clear, push, din, pop, dout, empty, full); the synchronizer, edge detect and FSM stay in toggle_hs_rx.

Verification
REQ-027 Reset: clear=1 with req_tog=0 -> ack_tog=0, out_valid=0, word_cnt=0, state IDLE.
REQ-028 Single word: req_tog 0->1, data_in=8'hA5, out_ready=0 -> out_valid=1 with out_data=8'hA5 after posedge k+3; ack_tog=1 after posedge k+4; word_cnt=1.
REQ-029 Backpressure: out_ready=0, three words 8'h11, 8'h22, 8'h33 each sent after the previous ack -> 2 acks, FSM held in CAPT with no third ack; raise out_ready -> 8'h11 popped, 8'h33 written, third ack; outputs in order 11, 22, 33.
REQ-030 Push/pop with 1 entry: buffer holds 8'h11, out_ready=1 on the CAPT cycle of 8'h22 -> occupancy stays 1, out_data=8'h22.
REQ-031 Wrap: 256 words sent and drained -> word_cnt returns to 0; ack_tog toggled 256 times, final level 0.
REQ-032 Mid-transfer reset: clear pulsed while state=CAPT -> no ack_tog toggle, out_valid=0, word_cnt=0; the next toggle is received normally.
